selector_rr_arbiter: RTL and testbench

- Parametrised successor to the one-hot combinational selector.
- Arbitrates between in_val requesting channels, each in_size bits wide, with per-channel valid/ready handshakes.
- Selects one channel per cycle by round-robin or fixed priority, and registers the chosen word with a one-hot grant tag into a single output stage with a valid/ready handshake.
- Sits between multiple producers and one shared downstream consumer.

---
 rtl/selector_rr_arbiter.sv | 93 +++++++++
 tb/tb_selector_rr_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/selector_rr_arbiter.sv
// selector_rr_arbiter: picks one of in_val requesting channels each cycle
// (round-robin or fixed priority) and registers the chosen word together with
// a one-hot grant tag into a single valid/ready output stage.
module selector_rr_arbiter #(
  parameter int in_size = 2,
  parameter int in_val  = 4,
  parameter int mode    = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [in_size*in_val-1:0] in,
  input  logic [in_val-1:0]         in_valid,
  output logic [in_val-1:0]         in_ready,
  input  logic [in_val-1:0]         en,
  output logic [in_size-1:0]        out,
  output logic [in_val-1:0]         out_grant,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int idx_w = $clog2(in_val);
  localparam int sh_w  = idx_w + 1;

  logic [idx_w-1:0]    last;
  logic [in_val-1:0]   req;
  logic [in_val-1:0]   rot;
  logic [in_val-1:0]   rot_pick;
  logic [in_val-1:0]   grant_rr;
  logic [in_val-1:0]   grant_fp;
  logic [in_val-1:0]   grant;
  logic [2*in_val-1:0] req_dbl;
  logic [2*in_val-1:0] back_dbl;
  logic [sh_w-1:0]     shamt;
  logic [idx_w-1:0]    grant_idx;
  logic [in_size-1:0]  sel_data;
  logic                accept;

  assign req    = in_valid & en;
  assign accept = !out_valid || out_ready;

  // Round-robin: rotate the request vector so the channel after 'last' lands
  // at bit 0, isolate the lowest set bit, then rotate the one-hot back.
  assign shamt    = sh_w'(last) + sh_w'(1);
  assign req_dbl  = {req, req};
  assign rot      = req_dbl[shamt +: in_val];
  assign rot_pick = rot & (~rot + in_val'(1));
  assign back_dbl = {{in_val{1'b0}}, rot_pick} << shamt;
  assign grant_rr = back_dbl[in_val-1:0] | back_dbl[2*in_val-1:in_val];

  // Fixed priority: lowest-index request wins.
  assign grant_fp = req & (~req + in_val'(1));

  assign grant = (mode == 1) ? grant_fp : grant_rr;

  // Reset holds off every producer so nothing is lost while the stage clears.
  assign in_ready = rst ? '0 : (grant & {in_val{accept}});

  // Encode the one-hot grant into an index for the round-robin pointer.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < in_val; i++) begin
      if (grant[i]) grant_idx = idx_w'(i);
    end
  end

  // Grant is one-hot, so an AND-OR mux over the slices selects the word.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < in_val; i++) begin
      sel_data = sel_data | (in[i*in_size +: in_size] & {in_size{grant[i]}});
    end
  end

  // Output stage and pointer: load on transfer, drain when idle, hold on stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      out_grant <= '0;
      out_valid <= 1'b0;
      last      <= idx_w'(in_val - 1);
    end else if (accept) begin
      if (grant != '0) begin
        out       <= sel_data;
        out_grant <= grant;
        out_valid <= 1'b1;
        if (mode == 0) last <= grant_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_selector_rr_arbiter.sv
// tb_selector_rr_arbiter: drives a round-robin and a fixed-priority instance
// with shared data/enable/back-pressure and compares both against a
// behavioural model every cycle, plus hand-computed directed expectations.
module tb_selector_rr_arbiter;

  localparam int N = 4;
  localparam int W = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [W*N-1:0] in_data;
  logic [N-1:0]   en;
  logic           out_ready;
  logic [N-1:0]   valid_rr, valid_fp;
  logic [N-1:0]   ready_rr, ready_fp;
  logic [N-1:0]   grant_rr, grant_fp;
  logic [W-1:0]   out_rr, out_fp;
  logic           ov_rr, ov_fp;

  int checks = 0;
  int passes = 0;

  logic [W-1:0] m_out   [2];
  logic [N-1:0] m_grant [2];
  logic         m_valid [2];
  int           m_last  [2];
  logic [W-1:0] n_out   [2];
  logic [N-1:0] n_grant [2];
  logic         n_valid [2];
  int           n_last  [2];
  logic [N-1:0] taken   [2];
  logic [N-1:0] held    [2];

  always #5 clk = ~clk;

  selector_rr_arbiter #(.in_size(W), .in_val(N), .mode(0)) dut_rr (
    .clk(clk), .rst(rst), .in(in_data), .in_valid(valid_rr), .in_ready(ready_rr),
    .en(en), .out(out_rr), .out_grant(grant_rr), .out_valid(ov_rr), .out_ready(out_ready)
  );

  selector_rr_arbiter #(.in_size(W), .in_val(N), .mode(1)) dut_fp (
    .clk(clk), .rst(rst), .in(in_data), .in_valid(valid_fp), .in_ready(ready_fp),
    .en(en), .out(out_fp), .out_grant(grant_fp), .out_valid(ov_fp), .out_ready(out_ready)
  );

  // Which channel the rules pick: -1 when nobody is requesting.
  function automatic int pick(input logic [N-1:0] req, input int last, input int md);
    if (md == 1) begin
      for (int i = 0; i < N; i++) if (req[i]) return i;
      return -1;
    end
    for (int k = 1; k <= N; k++) begin
      int j = (last + k) % N;
      if (req[j]) return j;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_out[m]   = '0;
      m_grant[m] = '0;
      m_valid[m] = 1'b0;
      m_last[m]  = N - 1;
    end
  endtask

  // Compare both instances against the model and work out the next model state.
  task automatic check_output();
    logic [N-1:0] req, oh, vld, act_ready, act_grant;
    logic [W-1:0] act_out;
    logic         act_v, acc;
    int           g;
    for (int m = 0; m < 2; m++) begin
      vld       = (m == 0) ? valid_rr : valid_fp;
      act_ready = (m == 0) ? ready_rr : ready_fp;
      act_grant = (m == 0) ? grant_rr : grant_fp;
      act_out   = (m == 0) ? out_rr : out_fp;
      act_v     = (m == 0) ? ov_rr : ov_fp;
      req = vld & en;
      acc = !m_valid[m] || out_ready;
      g   = pick(req, m_last[m], m);
      oh  = '0;
      if (g >= 0) oh[g] = 1'b1;
      chk($sformatf("in_ready[m%0d]", m), act_ready, acc ? oh : '0);
      chk($sformatf("out_valid[m%0d]", m), act_v, m_valid[m]);
      chk($sformatf("out[m%0d]", m), act_out, m_out[m]);
      chk($sformatf("out_grant[m%0d]", m), act_grant, m_grant[m]);
      n_out[m] = m_out[m]; n_grant[m] = m_grant[m];
      n_valid[m] = m_valid[m]; n_last[m] = m_last[m];
      taken[m] = acc ? oh : '0;
      if (acc) begin
        if (g >= 0) begin
          n_out[m]   = W'(in_data >> (W * g));
          n_grant[m] = oh;
          n_valid[m] = 1'b1;
          if (m == 0) n_last[m] = g;
        end else begin
          n_valid[m] = 1'b0;
        end
      end
    end
  endtask

  // One clock: check just after the inputs settle, commit on the edge,
  // return on the following falling edge ready for new stimulus.
  task automatic cycle();
    #1 check_output();
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      m_out[m] = n_out[m]; m_grant[m] = n_grant[m];
      m_valid[m] = n_valid[m]; m_last[m] = n_last[m];
    end
    held[0] = valid_rr & ~taken[0];
    held[1] = valid_fp & ~taken[1];
    @(negedge clk);
  endtask

  // Random traffic; a producer keeps its request up until it is accepted.
  task automatic apply_stimulus();
    in_data   = (W*N)'($urandom);
    en        = ($urandom_range(0, 4) == 0) ? N'($urandom) : '1;
    out_ready = ($urandom_range(0, 3) != 0);
    valid_rr  = held[0] | N'($urandom & $urandom);
    valid_fp  = held[1] | N'($urandom & $urandom);
  endtask

  initial begin
    logic [W-1:0] exp_out [5];
    logic [N-1:0] exp_g   [5];
    exp_out = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_g   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    rst = 1'b0; in_data = {2'd3, 2'd2, 2'd1, 2'd0};
    valid_rr = '1; valid_fp = '1; en = '1; out_ready = 1'b1;
    held[0] = '0; held[1] = '0; taken[0] = '0; taken[1] = '0;
    model_reset();

    #1 rst = 1'b1;
    #1;
    chk("reset out_valid", ov_rr, 1'b0);
    chk("reset out", out_rr, 2'd0);
    chk("reset out_grant", grant_rr, 4'b0000);
    chk("reset in_ready", ready_rr, 4'b0000);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1 chk("first in_ready", ready_rr, 4'b0001);

    cycle();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rotation out #%0d", i), out_rr, exp_out[i]);
      chk($sformatf("rotation grant #%0d", i), grant_rr, exp_g[i]);
      if (i < 4) cycle();
    end

    out_ready = 1'b0;
    repeat (3) cycle();
    chk("stall out", out_rr, 2'd0);
    chk("stall grant", grant_rr, 4'b0001);
    #1 chk("stall in_ready", ready_rr, 4'b0000);
    out_ready = 1'b1;
    cycle();
    chk("resume grant", grant_rr, 4'b0010);
    chk("resume out", out_rr, 2'd1);

    valid_rr = 4'b0100; valid_fp = 4'b0100;
    cycle();
    chk("sparse ch2", grant_rr, 4'b0100);
    valid_rr = 4'b1010; valid_fp = 4'b1010;
    cycle();
    chk("wrap ch3 first", grant_rr, 4'b1000);
    cycle();
    chk("wrap ch1 next", grant_rr, 4'b0010);
    valid_rr = 4'b0010; valid_fp = 4'b0010;
    repeat (2) cycle();
    chk("single ch1", grant_rr, 4'b0010);

    valid_rr = '1; valid_fp = '1; en = 4'b1110;
    repeat (3) cycle();
    chk("fixed masked grant", grant_fp, 4'b0010);
    en = 4'b0000;
    repeat (2) cycle();
    chk("drain fp", ov_fp, 1'b0);
    chk("drain rr", ov_rr, 1'b0);

    en = '1;
    repeat (2) cycle();
    chk("busy before reset", ov_rr, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async reset rr", ov_rr, 1'b0);
    chk("async reset fp", ov_fp, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1 chk("restart in_ready", ready_rr, 4'b0001);
    cycle();
    chk("restart grant", grant_rr, 4'b0001);

    held[0] = '0; held[1] = '0;
    repeat (1500) begin
      apply_stimulus();
      cycle();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
